updown_mod_counter: RTL

UPDOWN_MOD_COUNTER -- requirements
Module: updown_mod_counter

---
 rtl/counter_pkg.sv | 16 +
 rtl/bin2gray.sv | 11 +
 rtl/updown_mod_counter.sv | 109 ++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the up/down modulo counter: mode encodings and a
// small helper used to recognise the hold mode.
package counter_pkg;

    typedef enum logic [1:0] {
        MODE_UP       = 2'b00,
        MODE_DOWN     = 2'b01,
        MODE_PINGPONG = 2'b10,
        MODE_HOLD     = 2'b11
    } mode_e;

    function automatic logic is_hold(input logic [1:0] mode);
        return mode_e'(mode) == MODE_HOLD;
    endfunction

endpackage

// File: rtl/bin2gray.sv
// Purely combinational binary-to-Gray converter.
module bin2gray #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] bin_i,
    output logic [WIDTH-1:0] gray_o
);

    assign gray_o = bin_i ^ (bin_i >> 1);

endmodule

// File: rtl/updown_mod_counter.sv
// Modulo-N counter with up, down, ping-pong and hold modes, parallel load,
// registered direction and terminal-count pulse, plus a Gray-coded view.
module updown_mod_counter
    import counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] gray,
    output logic             dir,
    output logic             tc
);

    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ONE_C = WIDTH'(1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             dir_q, dir_d;
    logic             tc_q, tc_d;

    always_comb begin
        count_d = count_q;
        dir_d   = dir_q;
        tc_d    = 1'b0;
        if (load) begin
            count_d = (32'(load_val) >= MODULUS) ? MAX_C : load_val;
        end else if (en && !is_hold(mode)) begin
            case (mode_e'(mode))
                MODE_UP: begin
                    dir_d = 1'b1;
                    if (count_q == MAX_C) begin
                        count_d = '0;
                        tc_d    = 1'b1;
                    end else begin
                        count_d = count_q + ONE_C;
                    end
                end
                MODE_DOWN: begin
                    dir_d = 1'b0;
                    if (count_q == '0) begin
                        count_d = MAX_C;
                        tc_d    = 1'b1;
                    end else begin
                        count_d = count_q - ONE_C;
                    end
                end
                MODE_PINGPONG: begin
                    // Ranges of one or two values turn around on every step.
                    if (MODULUS == 1) begin
                        count_d = '0;
                        dir_d   = !dir_q;
                        tc_d    = 1'b1;
                    end else if (MODULUS == 2) begin
                        count_d = WIDTH'(!count_q[0]);
                        dir_d   = !dir_q;
                        tc_d    = 1'b1;
                    end else if (dir_q) begin
                        if (count_q == MAX_C) begin
                            count_d = MAX_C - ONE_C;
                            dir_d   = 1'b0;
                            tc_d    = 1'b1;
                        end else begin
                            count_d = count_q + ONE_C;
                        end
                    end else begin
                        if (count_q == '0) begin
                            count_d = ONE_C;
                            dir_d   = 1'b1;
                            tc_d    = 1'b1;
                        end else begin
                            count_d = count_q - ONE_C;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            dir_q   <= 1'b1;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            dir_q   <= dir_d;
            tc_q    <= tc_d;
        end
    end

    assign count = count_q;
    assign dir   = dir_q;
    assign tc    = tc_q;

    bin2gray #(.WIDTH(WIDTH)) u_bin2gray (
        .bin_i  (count_q),
        .gray_o (gray)
    );

endmodule
